// File: rtl/serializer_sched.sv
// serializer_sched: round-robin scheduler that shares one serializer among
// N_REQ burst requesters. It issues start/length to the serializer, follows
// the burst through bit_valid, and returns a per-requester done/err pulse.
// Every burst is supervised by a start timeout and a run-length timeout.
module serializer_sched #(
  parameter int N_REQ      = 4,
  parameter int GAP_CYCLES = 2,
  parameter int START_TO   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [8*N_REQ-1:0] len_i,
  output logic [N_REQ-1:0]   grant_o,
  output logic [N_REQ-1:0]   done_o,
  output logic [N_REQ-1:0]   err_o,
  output logic               ser_start_o,
  output logic [7:0]         ser_length_o,
  input  logic               ser_bit_valid_i,
  output logic               busy_o,
  output logic               timeout_sticky_o
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(N_REQ - 1);
  // Last WAIT_VALID count before the start timeout fires.
  localparam logic [12:0] START_LAST = 13'(START_TO - 1);
  // GAP_CYCLES = 0 still spends one cycle in GAP.
  localparam logic [12:0] GAP_LAST = 13'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_VALID,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t             state_reg, state_next;
  logic [12:0]        cnt_reg, cnt_next;
  logic [PTR_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [N_REQ-1:0]   grant_reg, grant_next;
  logic [N_REQ-1:0]   zl_reg, zl_next;
  logic [7:0]         len_reg, len_next;
  logic               sticky_reg, sticky_next;

  logic [7:0]         req_len [N_REQ];
  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   scan_idx;
  logic [N_REQ-1:0]   win_onehot;
  logic [7:0]         win_len;
  logic [PTR_W-1:0]   rr_ptr_after;
  logic [12:0]        done_last;
  logic               fin;
  logic               fin_err;

  // Split the flat length bus into one byte per requester.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_len
      assign req_len[gi] = len_i[8*gi +: 8];
    end
  endgenerate

  // Round-robin search: first pending request at or after rr_ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      scan_idx = PTR_W'((int'(rr_ptr_reg) + i) % N_REQ);
      if (!win_found && req_i[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  assign win_onehot   = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
  assign win_len      = req_len[win_idx];
  assign rr_ptr_after = (win_idx == PTR_MAX) ? '0 : win_idx + 1'b1;

  // Stuck-valid limit: 16*len + 8 cycles, counted from zero.
  assign done_last = {1'b0, len_reg, 4'b0000} + 13'd7;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      rr_ptr_reg <= '0;
      grant_reg  <= '0;
      zl_reg     <= '0;
      len_reg    <= '0;
      sticky_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      rr_ptr_reg <= rr_ptr_next;
      grant_reg  <= grant_next;
      zl_reg     <= zl_next;
      len_reg    <= len_next;
      sticky_reg <= sticky_next;
    end
  end

  // Next-state logic; fin/fin_err flag the cycle a granted burst completes.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    rr_ptr_next = rr_ptr_reg;
    grant_next  = grant_reg;
    zl_next     = '0;
    len_next    = len_reg;
    sticky_next = sticky_reg;
    fin         = 1'b0;
    fin_err     = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (win_found) begin
          rr_ptr_next = rr_ptr_after;
          cnt_next    = '0;
          if (win_len == 8'd0) begin
            // The serializer reads 0 as 256 words, so never start it;
            // the length register keeps its last nonzero value.
            zl_next    = win_onehot;
            state_next = S_GAP;
          end else begin
            len_next   = win_len;
            grant_next = win_onehot;
            state_next = S_START;
          end
        end
      end

      S_START: begin
        cnt_next   = '0;
        state_next = S_WAIT_VALID;
      end

      S_WAIT_VALID: begin
        if (ser_bit_valid_i) begin
          cnt_next   = '0;
          state_next = S_WAIT_DONE;
        end else if (cnt_reg >= START_LAST) begin
          fin         = 1'b1;
          fin_err     = 1'b1;
          sticky_next = 1'b1;
          grant_next  = '0;
          cnt_next    = '0;
          state_next  = S_GAP;
        end else begin
          cnt_next = cnt_reg + 13'd1;
        end
      end

      S_WAIT_DONE: begin
        if (!ser_bit_valid_i) begin
          fin        = 1'b1;
          grant_next = '0;
          cnt_next   = '0;
          state_next = S_GAP;
        end else if (cnt_reg >= done_last) begin
          fin         = 1'b1;
          fin_err     = 1'b1;
          sticky_next = 1'b1;
          grant_next  = '0;
          cnt_next    = '0;
          state_next  = S_GAP;
        end else begin
          cnt_next = cnt_reg + 13'd1;
        end
      end

      S_GAP: begin
        if (cnt_reg >= GAP_LAST) begin
          cnt_next   = '0;
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt_reg + 13'd1;
        end
      end

      default: begin
        grant_next = '0;
        cnt_next   = '0;
        state_next = S_IDLE;
      end
    endcase
  end

  // Completion is reported in the cycle the FSM decides it, so the
  // requester sees done in the first cycle bit_valid is low.
  assign done_o           = ({N_REQ{fin}} & grant_reg) | zl_reg;
  assign err_o            = ({N_REQ{fin_err}} & grant_reg) | zl_reg;
  assign grant_o          = grant_reg;
  assign ser_start_o      = (state_reg == S_START);
  assign ser_length_o     = len_reg;
  assign busy_o           = (state_reg != S_IDLE);
  assign timeout_sticky_o = sticky_reg;

endmodule
